// File: rtl/multicycle_controller.sv
// Multicycle RISC-V controller: sequences one instruction over 3-5 cycles on a
// shared instruction/data memory, with memory wait states, optional bne and
// extended ALU ops, and a sticky illegal-opcode trap.
module multicycle_controller #(
    parameter int unsigned ALU_EXT = 0,
    parameter int unsigned BNE_EN  = 0,
    parameter int unsigned ACW     = (ALU_EXT != 0) ? 4 : 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [6:0]     op,
    input  logic [2:0]     funct3,
    input  logic           funct7b5,
    input  logic           Zero,
    input  logic           MemReady,
    output logic           PCWrite,
    output logic           AdrSrc,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic [1:0]     ResultSrc,
    output logic [1:0]     ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic           RegWrite,
    output logic [1:0]     ImmSrc,
    output logic [ACW-1:0] ALUControl,
    output logic           Trap,
    output logic [3:0]     State
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] alu_op;
    logic       trap_q;
    logic       bne_sel;

    // bne inverts the branch sense when enabled and funct3 selects it
    assign bne_sel = (BNE_EN != 0) && (funct3 == 3'b001);

    // State register with synchronous reset back to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Sticky trap flag: raised on entry to TRAP, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else if (state_nxt == S_TRAP) begin
            trap_q <= 1'b1;
        end
    end

    // Next-state and Moore control outputs; everything defaults to 0
    always_comb begin
        state_nxt = state;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        alu_op    = 2'b00;
        case (state)
            S_FETCH: begin
                AdrSrc    = 1'b0;
                ALUSrcA   = 2'b00;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    default:           state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                state_nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) begin
                    state_nxt = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) begin
                    state_nxt = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b00;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = 2'b00;
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b00;
                PCWrite   = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b00;
                alu_op    = 2'b01;
                ResultSrc = 2'b00;
                PCWrite   = Zero ^ bne_sel;
                state_nxt = S_FETCH;
            end
            S_TRAP: begin
                state_nxt = S_TRAP;
            end
            default: begin
                state_nxt = S_TRAP;
            end
        endcase
    end

    // ALU decoder; extended ops only exist when ALU_EXT is set
    always_comb begin
        ALUControl = ACW'(4'd0);
        case (alu_op)
            2'b00: ALUControl = ACW'(4'd0);
            2'b01: ALUControl = ACW'(4'd1);
            2'b10: begin
                case (funct3)
                    3'b000: ALUControl = (op[5] && funct7b5) ? ACW'(4'd1) : ACW'(4'd0);
                    3'b010: ALUControl = ACW'(4'd5);
                    3'b110: ALUControl = ACW'(4'd3);
                    3'b111: ALUControl = ACW'(4'd2);
                    3'b100: ALUControl = (ALU_EXT != 0) ? ACW'(4'd4) : ACW'(4'd0);
                    3'b001: ALUControl = (ALU_EXT != 0) ? ACW'(4'd6) : ACW'(4'd0);
                    3'b101: begin
                        if (ALU_EXT != 0) begin
                            ALUControl = funct7b5 ? ACW'(4'd8) : ACW'(4'd7);
                        end else begin
                            ALUControl = ACW'(4'd0);
                        end
                    end
                    default: ALUControl = ACW'(4'd0);
                endcase
            end
            default: ALUControl = ACW'(4'd0);
        endcase
    end

    // Immediate format follows the opcode regardless of state
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    assign Trap  = trap_q;
    assign State = state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle successor to the single-cycle RISC-V controller; owns a state machine that sequences one instruction over 3–5 cycles on a shared instruction/data memory.
- Drives datapath register enables, mux selects and ALU control.
- Adds three things the single-cycle controller does not have:
  - memory wait states via a ready handshake;
  - optional bne and extended ALU ops;
  - a sticky illegal-opcode trap.

Parameters:
- ALU_EXT, 0: 1 enables xor/sll/srl/sra decode. ALUControl becomes 4 bits.
- BNE_EN, 0: 1 makes the branch state honour funct3=001 (bne) as well as beq.
- ACW, ALU_EXT?4:3: ALUControl width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  7  instruction opcode from the instruction register (IR).
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALU result.
- MemWrite  out  1  data memory write strobe.
- IRWrite  out  1  IR and OldPC enable.
- ResultSrc  out  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1.
- ALUSrcB  out  2  ALU B select: 00=rs2, 01=imm, 10=4.
- RegWrite  out  1  register file write enable.
- ImmSrc  out  2  immediate format: 00=I, 01=S, 10=B, 11=J.
- ALUControl  out  ACW  ALU operation.
- Trap  out  1  sticky illegal-instruction flag.
- State  out  4  current state encoding, for debug.

Behaviour:
- States and encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, TRAP=11.
- Reset (checked on the clock edge): State=FETCH, Trap=0.
- Moore control outputs: every control output not listed for a state is 0 in that state.
- FETCH:
  - Fixed outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00.
  - IRWrite=1 and PCWrite=1 only while MemReady=1.
  - Stays in FETCH while MemReady=0; moves to DECODE on MemReady=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BRANCH
  - anything else -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op=0000011 -> MEMREAD, otherwise -> MEMWRITE.
- MEMREAD: AdrSrc=1. Stays while MemReady=0; -> MEMWB on MemReady=1.
- MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1. Stays while MemReady=0; -> FETCH on MemReady=1. MemWrite is held high for the whole wait.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1, RegWrite=0; -> ALUWB, which writes PC+4 to rd.
- BRANCH:
  - Fixed outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite = Zero XOR (BNE_EN & funct3==001); combinational within the state.
  - -> FETCH.
- TRAP:
  - Trap=1, sticky; all enables are 0.
  - Stays in TRAP until reset.
  - Reset during any state, including a memory wait, returns to FETCH on the next edge.
- ImmSrc is combinational from op:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - all others -> 00
- ALU decoder (ALUOp is internal):
  - ALUOp 00 -> add (000).
  - ALUOp 01 -> sub (001).
  - ALUOp 10, by funct3:
    - 000 -> sub if op[5]&funct7b5, else add
    - 010 -> slt (101)
    - 110 -> or (011)
    - 111 -> and (010)
  - ALU_EXT=1 adds, for ALUOp 10:
    - 100 -> xor (0100)
    - 001 -> sll (0110)
    - 101 -> srl (0111) if funct7b5=0, sra (1000) if funct7b5=1
  - With ALU_EXT=1, all 3-bit codes are zero-extended to 4 bits.
  - Unlisted funct3 -> add; no trap.

Test Plan:
- add, MemReady=1: reset then op=0110011, funct3=000, funct7b5=0 -> State sequence 0,1,6,7,0; ALUControl=000 in EXECR; RegWrite=1 only in ALUWB.
- lw with wait: op=0000011, MemReady low for 2 cycles in MEMREAD -> sequence 0,1,2,3,3,3,4,0; AdrSrc=1 throughout MEMREAD; RegWrite=1 with ResultSrc=01 in MEMWB.
- Fetch stall and store: MemReady=0 for 3 cycles in FETCH -> IRWrite=0 and PCWrite=0 until the ready cycle. Then sw (0100011) -> ImmSrc=01; MemWrite=1 held in MEMWRITE until MemReady.
- Branches:
  - beq with Zero=1 -> PCWrite=1 in BRANCH; with Zero=0 -> PCWrite=0.
  - BNE_EN=1, funct3=001, Zero=0 -> PCWrite=1.
- Extended ALU: ALU_EXT=1, op=0110011, funct3=101, funct7b5=1 -> ALUControl=1000. Same with funct7b5=0 -> 0111.
- Illegal opcode: op=1111111 -> DECODE goes to TRAP; Trap=1 and State=11 held for 5+ cycles. Reset asserted for 1 cycle -> State=0, Trap=0.
